// File: rtl/lcd_menu_writer.sv
// Menu renderer: tracks a wrap-around selection from button pulses and redraws
// an N_LINES x LINE_CHARS LCD through an Avalon-MM slave, one write per frame slot k.
module lcd_menu_writer #(
  parameter int N_OPTIONS  = 4,
  parameter int LINE_CHARS = 16,
  parameter int N_LINES    = 2,
  parameter int CW         = $clog2(N_OPTIONS),
  parameter int TAW        = $clog2(N_OPTIONS*N_LINES*LINE_CHARS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_next,
  input  logic           btn_prev,
  output logic [CW-1:0]  menu_choice,
  output logic [TAW-1:0] text_addr,
  input  logic [7:0]     text_char,
  output logic           address,
  output logic           chipselect,
  output logic           byteenable,
  output logic           read,
  output logic           write,
  output logic [7:0]     writedata,
  input  logic           waitrequest,
  output logic           busy,
  output logic           frame_done
);

  localparam int NW = 1 + N_LINES*LINE_CHARS + (N_LINES-1);
  localparam int KW = $clog2(NW+1);
  localparam logic [KW-1:0] K_LAST = KW'(NW-1);
  localparam logic [KW-1:0] K_CMD  = KW'(LINE_CHARS+1);

  // Handshake: a write is held with stable address/writedata while write=1 and
  // waitrequest=1; it is accepted on the rising edge where waitrequest=0.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic          redraw_pending;

  logic [KW-1:0] k_nxt;
  logic          ln;
  logic [KW-1:0] col;
  logic          nxt_addr;
  logic [7:0]    nxt_data;
  logic          sel_change;
  logic [CW-1:0] choice_nxt;

  // k_nxt is the slot that the next ISSUE will carry; the ROM is addressed for it
  // ahead of time so the character can be registered on entry to ISSUE.
  always_comb begin
    k_nxt = '0;
    if (state == ISSUE)
      k_nxt = k;
    else if (state == GAP && !redraw_pending && k != K_LAST)
      k_nxt = k + 1'b1;
  end

  always_comb begin
    nxt_addr = 1'b1;
    nxt_data = text_char;
    ln       = 1'b0;
    col      = '0;
    if (k_nxt == '0) begin
      nxt_addr = 1'b0;
      nxt_data = 8'h01;
    end else if (N_LINES == 2 && k_nxt == K_CMD) begin
      nxt_addr = 1'b0;
      nxt_data = 8'hC0;
    end else if (k_nxt > K_CMD) begin
      ln  = 1'b1;
      col = k_nxt - KW'(LINE_CHARS+2);
    end else begin
      col = k_nxt - 1'b1;
    end
  end

  assign text_addr = TAW'(int'(menu_choice)*(N_LINES*LINE_CHARS)
                          + int'(ln)*LINE_CHARS + int'(col));

  always_comb begin
    sel_change = btn_next ^ btn_prev;
    choice_nxt = menu_choice;
    if (btn_next && !btn_prev)
      choice_nxt = (menu_choice == CW'(N_OPTIONS-1)) ? '0 : menu_choice + 1'b1;
    else if (btn_prev && !btn_next)
      choice_nxt = (menu_choice == '0) ? CW'(N_OPTIONS-1) : menu_choice - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      k              <= '0;
      menu_choice    <= '0;
      redraw_pending <= 1'b1;
      write          <= 1'b0;
      address        <= 1'b0;
      writedata      <= 8'h00;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sel_change) menu_choice <= choice_nxt;
      case (state)
        IDLE: begin
          if (redraw_pending) begin
            state          <= ISSUE;
            k              <= '0;
            redraw_pending <= 1'b0;
            write          <= 1'b1;
            address        <= nxt_addr;
            writedata      <= nxt_data;
          end
        end
        ISSUE: begin
          if (!waitrequest) begin
            state     <= GAP;
            write     <= 1'b0;
            address   <= 1'b0;
            writedata <= 8'h00;
          end
        end
        GAP: begin
          if (redraw_pending || k != K_LAST) begin
            state          <= ISSUE;
            k              <= k_nxt;
            redraw_pending <= 1'b0;
            write          <= 1'b1;
            address        <= nxt_addr;
            writedata      <= nxt_data;
          end else begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // A selection change on the same edge as a restart must survive it.
      if (sel_change) redraw_pending <= 1'b1;
    end
  end

  assign chipselect = write;
  assign byteenable = 1'b1;
  assign read       = 1'b0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_lcd_menu_writer.sv
// Directed bench for lcd_menu_writer: three geometries share clock and reset;
// each scenario task checks its own results against hand-derived frames.
module tb_lcd_menu_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: N_OPTIONS=3. Instance 2: N_LINES=1, LINE_CHARS=8.
  logic [2:0]      wr, adr, cs, be, rd, bsy, fd, wreq, bn, bp;
  logic [2:0][7:0] wd, tc;
  logic [2:0][1:0] mc;
  logic [2:0][6:0] ta;
  logic [4:0]      ta_nl1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fd_cnt[3];
  int fd_cyc[3];
  int first_cyc[3];
  logic [8:0] cap_q[3][$];
  logic [8:0] exp_q[$];

  function automatic logic [7:0] rom(input logic [6:0] a);
    logic [7:0] v;
    v = {1'b0, a};
    return v*8'd5 + 8'h21;
  endfunction

  assign tc[0] = rom(ta[0]);
  assign tc[1] = rom(ta[1]);
  assign ta[2] = {2'b00, ta_nl1};
  assign tc[2] = rom(ta[2]);

  lcd_menu_writer u_def (
    .clk(clk), .rst_n(rst_n), .btn_next(bn[0]), .btn_prev(bp[0]),
    .menu_choice(mc[0]), .text_addr(ta[0]), .text_char(tc[0]),
    .address(adr[0]), .chipselect(cs[0]), .byteenable(be[0]), .read(rd[0]),
    .write(wr[0]), .writedata(wd[0]), .waitrequest(wreq[0]),
    .busy(bsy[0]), .frame_done(fd[0]));

  lcd_menu_writer #(.N_OPTIONS(3)) u_opt3 (
    .clk(clk), .rst_n(rst_n), .btn_next(bn[1]), .btn_prev(bp[1]),
    .menu_choice(mc[1]), .text_addr(ta[1]), .text_char(tc[1]),
    .address(adr[1]), .chipselect(cs[1]), .byteenable(be[1]), .read(rd[1]),
    .write(wr[1]), .writedata(wd[1]), .waitrequest(wreq[1]),
    .busy(bsy[1]), .frame_done(fd[1]));

  lcd_menu_writer #(.N_LINES(1), .LINE_CHARS(8)) u_nl1 (
    .clk(clk), .rst_n(rst_n), .btn_next(bn[2]), .btn_prev(bp[2]),
    .menu_choice(mc[2]), .text_addr(ta_nl1), .text_char(tc[2]),
    .address(adr[2]), .chipselect(cs[2]), .byteenable(be[2]), .read(rd[2]),
    .write(wr[2]), .writedata(wd[2]), .waitrequest(wreq[2]),
    .busy(bsy[2]), .frame_done(fd[2]));

  always @(posedge clk) cyc++;

  // Monitor: records accepted writes as {address, data} and frame_done events.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (rst_n) begin
        if (wr[u] && first_cyc[u] < 0) first_cyc[u] = cyc;
        if (wr[u] && !wreq[u]) cap_q[u].push_back({adr[u], wd[u]});
        if (fd[u]) begin
          fd_cnt[u]++;
          fd_cyc[u] = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    for (int u = 0; u < 3; u++) begin
      cap_q[u].delete();
      first_cyc[u] = -1;
    end
  endtask

  task automatic build_exp(input int base, input int lc, input int nl);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h01});
    for (int c = 0; c < lc; c++) exp_q.push_back({1'b1, rom(7'(base + c))});
    if (nl == 2) begin
      exp_q.push_back({1'b0, 8'hC0});
      for (int c = 0; c < lc; c++) exp_q.push_back({1'b1, rom(7'(base + lc + c))});
    end
  endtask

  task automatic wait_fd(input int u, input int start, output bit ok);
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt[u] != start) break;
      @(negedge clk);
    end
    ok = (fd_cnt[u] != start);
  endtask

  task automatic find_k(input int u, input int kk, output bit ok);
    for (int i = 0; i < 300; i++) begin
      if (wr[u] && cap_q[u].size() == kk) break;
      tick();
    end
    ok = wr[u] && cap_q[u].size() == kk;
  endtask

  task automatic pulse(input int u, input bit nxt, input bit prv);
    bn[u] = nxt;
    bp[u] = prv;
    tick();
    bn[u] = 1'b0;
    bp[u] = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got [9];
    logic [7:0] req [9];
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    got = '{8'(wr[0]), 8'(cs[0]), wd[0], 8'(adr[0]), 8'(bsy[0]), 8'(fd[0]),
            8'(rd[0]), 8'(be[0]), 8'(mc[0])};
    req = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (got[i] !== req[i]) begin
        miscompares++;
        $display("FAIL reset_out%0d got %h want %h", i, got[i], req[i]);
      end
    end
  endtask

  task automatic release_reset();
    tick();
    clear_caps();
    for (int u = 0; u < 3; u++) fd_cnt[u] = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_frame_default();
    bit ok;
    wait_fd(0, 0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL default_done timeout got 0 want 1"); end
    build_exp(0, 16, 2);
    vectors++;
    if (cap_q[0].size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL default_count got %0d want %0d", cap_q[0].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q[0].size() || cap_q[0][i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL default_w%0d got %h want %h", i,
                 (i < cap_q[0].size()) ? cap_q[0][i] : 9'h1ff, exp_q[i]);
      end
    end
    vectors++;
    if (fd_cyc[0] - first_cyc[0] !== 68) begin
      miscompares++;
      $display("FAIL default_len got %0d want 68", fd_cyc[0] - first_cyc[0]);
    end
    @(negedge clk);
    vectors++;
    if (bsy[0] !== 1'b0) begin miscompares++; $display("FAIL default_busy got %b want 0", bsy[0]); end
  endtask

  task automatic test_one_line();
    bit ok;
    wait_fd(2, 0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL nl1_done timeout got 0 want 1"); end
    build_exp(0, 8, 1);
    vectors++;
    if (cap_q[2].size() !== 9) begin
      miscompares++;
      $display("FAIL nl1_count got %0d want 9", cap_q[2].size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q[2].size() || cap_q[2][i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL nl1_w%0d got %h want %h", i,
                 (i < cap_q[2].size()) ? cap_q[2][i] : 9'h1ff, exp_q[i]);
      end
    end
    vectors++;
    if (fd_cyc[2] - first_cyc[2] !== 18) begin
      miscompares++;
      $display("FAIL nl1_len got %0d want 18", fd_cyc[2] - first_cyc[2]);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int start;
    logic [8:0] held;
    clear_caps();
    start = fd_cnt[0];
    pulse(0, 1'b1, 1'b0);
    find_k(0, 3, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stall_find timeout got 0 want 1"); end
    held = {adr[0], wd[0]};
    wreq[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j == 5) wreq[0] = 1'b0;
      @(negedge clk);
      vectors++;
      if (wr[0] !== 1'b1 || {adr[0], wd[0]} !== held) begin
        miscompares++;
        $display("FAIL stall_hold%0d got %b/%h want 1/%h", j, wr[0], {adr[0], wd[0]}, held);
      end
      tick();
    end
    wait_fd(0, start, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stall_done timeout got 0 want 1"); end
    build_exp(32, 16, 2);
    vectors++;
    if (mc[0] !== 2'd1) begin miscompares++; $display("FAIL stall_choice got %0d want 1", mc[0]); end
    vectors++;
    if (cap_q[0].size() !== 34) begin
      miscompares++;
      $display("FAIL stall_count got %0d want 34", cap_q[0].size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q[0].size() || cap_q[0][i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_w%0d got %h want %h", i,
                 (i < cap_q[0].size()) ? cap_q[0][i] : 9'h1ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int start;
    int bases [2];
    logic [1:0] want_mc [2];
    bases = '{64, 0};
    want_mc = '{2'd2, 2'd0};
    for (int s = 0; s < 2; s++) begin
      clear_caps();
      start = fd_cnt[1];
      pulse(1, s == 1, s == 0);
      @(negedge clk);
      vectors++;
      if (mc[1] !== want_mc[s]) begin
        miscompares++;
        $display("FAIL wrap%0d_choice got %0d want %0d", s, mc[1], want_mc[s]);
      end
      wait_fd(1, start, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL wrap%0d_done timeout got 0 want 1", s); end
      build_exp(bases[s], 16, 2);
      vectors++;
      if (cap_q[1].size() !== 34) begin
        miscompares++;
        $display("FAIL wrap%0d_count got %0d want 34", s, cap_q[1].size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (i >= cap_q[1].size() || cap_q[1][i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL wrap%0d_w%0d got %h want %h", s, i,
                   (i < cap_q[1].size()) ? cap_q[1][i] : 9'h1ff, exp_q[i]);
        end
      end
    end
    clear_caps();
    start = fd_cnt[1];
    pulse(1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    vectors++;
    if (mc[1] !== 2'd0 || bsy[1] !== 1'b0 || cap_q[1].size() !== 0 || fd_cnt[1] !== start) begin
      miscompares++;
      $display("FAIL both_btn got mc=%0d busy=%b writes=%0d want mc=0 busy=0 writes=0",
               mc[1], bsy[1], cap_q[1].size());
    end
  endtask

  task automatic test_restart();
    bit ok;
    int start;
    logic [8:0] first_part[$];
    clear_caps();
    start = fd_cnt[0];
    pulse(0, 1'b1, 1'b0);
    find_k(0, 10, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL restart_find timeout got 0 want 1"); end
    wreq[0] = 1'b1;
    tick();
    pulse(0, 1'b1, 1'b0);
    wreq[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (wr[0] !== 1'b1) begin miscompares++; $display("FAIL restart_accept got %b want 1", wr[0]); end
    tick();
    @(negedge clk);
    vectors++;
    if (wr[0] !== 1'b0) begin miscompares++; $display("FAIL restart_gap got %b want 0", wr[0]); end
    tick();
    @(negedge clk);
    vectors++;
    if ({wr[0], adr[0], wd[0]} !== {2'b10, 8'h01}) begin
      miscompares++;
      $display("FAIL restart_clear got %b/%b/%h want 1/0/01", wr[0], adr[0], wd[0]);
    end
    wait_fd(0, start, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL restart_done timeout got 0 want 1"); end
    repeat (10) @(negedge clk);
    vectors++;
    if (fd_cnt[0] - start !== 1) begin
      miscompares++;
      $display("FAIL restart_fd_count got %0d want 1", fd_cnt[0] - start);
    end
    build_exp(64, 16, 2);
    for (int i = 0; i < 11; i++) first_part.push_back(exp_q[i]);
    build_exp(96, 16, 2);
    exp_q = {first_part, exp_q};
    vectors++;
    if (cap_q[0].size() !== 45) begin
      miscompares++;
      $display("FAIL restart_count got %0d want 45", cap_q[0].size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q[0].size() || cap_q[0][i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL restart_w%0d got %h want %h", i,
                 (i < cap_q[0].size()) ? cap_q[0][i] : 9'h1ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_caps();
    pulse(0, 1'b0, 1'b1);
    find_k(0, 5, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rstmid_find timeout got 0 want 1"); end
    wreq[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({wr[0], cs[0], mc[0], bsy[0]} !== 5'b0) begin
      miscompares++;
      $display("FAIL rstmid_outs got wr=%b cs=%b mc=%0d busy=%b want 0/0/0/0",
               wr[0], cs[0], mc[0], bsy[0]);
    end
    wreq[0] = 1'b0;
    tick();
    release_reset();
    wait_fd(0, 0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rstmid_done timeout got 0 want 1"); end
    build_exp(0, 16, 2);
    vectors++;
    if (cap_q[0].size() !== 34) begin
      miscompares++;
      $display("FAIL rstmid_count got %0d want 34", cap_q[0].size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q[0].size() || cap_q[0][i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rstmid_w%0d got %h want %h", i,
                 (i < cap_q[0].size()) ? cap_q[0][i] : 9'h1ff, exp_q[i]);
      end
    end
    vectors++;
    if (fd_cyc[0] - first_cyc[0] !== 68) begin
      miscompares++;
      $display("FAIL rstmid_len got %0d want 68", fd_cyc[0] - first_cyc[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bn = '0;
    bp = '0;
    wreq = '0;
    for (int u = 0; u < 3; u++) begin
      fd_cnt[u] = 0;
      fd_cyc[u] = 0;
      first_cyc[u] = -1;
    end
    test_reset();
    release_reset();
    test_frame_default();
    test_one_line();
    test_stall();
    test_wrap();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
